// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared definitions for the fetch prefetch queue: opcode field layout,
// reset defaults and the pop-size encoding used between top and FIFO.
package fetch_prefetch_queue_pkg;

  localparam int         DEPTH_DEFAULT    = 4;
  localparam logic [7:0] RESET_PC_DEFAULT = 8'h00;
  localparam logic [1:0] IMM_OP_CODE      = 2'b00;

  localparam int OP_HI = 7;
  localparam int OP_LO = 6;

  typedef enum logic [1:0] {
    POP_NONE = 2'd0,
    POP_ONE  = 2'd1,
    POP_TWO  = 2'd2
  } pop_e;

  function automatic logic is_imm_class(input logic [7:0] code, input logic [1:0] imm_op);
    return (code[OP_HI:OP_LO] == imm_op);
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// ROM request/response, redirect and decode-side handshake of the prefetch queue.
interface fetch_prefetch_queue_if #(
  parameter int PC_W = 8
);
  logic            Mem_Req;
  logic [PC_W-1:0] Mem_Addr;
  logic [7:0]      Mem_RData;
  logic            Redirect_Valid;
  logic [PC_W-1:0] Redirect_PC;
  logic            Out_Valid;
  logic            Out_Ready;
  logic [7:0]      Out_Code;
  logic [7:0]      Out_Imm;
  logic [PC_W-1:0] Out_PC;
  logic            Out_ImmSel;

  modport master (
    output Mem_Req, Mem_Addr, Out_Valid, Out_Code, Out_Imm, Out_PC, Out_ImmSel,
    input  Mem_RData, Redirect_Valid, Redirect_PC, Out_Ready
  );

  modport slave (
    input  Mem_Req, Mem_Addr, Out_Valid, Out_Code, Out_Imm, Out_PC, Out_ImmSel,
    output Mem_RData, Redirect_Valid, Redirect_PC, Out_Ready
  );
endinterface

// File: rtl/fetch_prefetch_queue_prefetch_fifo.sv
// Byte+address FIFO with single push, pop of one or two entries, flush,
// and peek of the head and the entry behind it.
module prefetch_fifo
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int PC_W  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [7:0]                   push_byte,
  input  logic [PC_W-1:0]              push_pc,
  input  pop_e                         pop,
  output logic [7:0]                   head_byte,
  output logic [PC_W-1:0]              head_pc,
  output logic [7:0]                   next_byte,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [7:0]      data_q [DEPTH];
  logic [PC_W-1:0] addr_q [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [PW-1:0]   next_idx;
  logic [CW-1:0]   pop_len;

  always_comb begin
    pop_len = '0;
    case (pop)
      POP_ONE: pop_len = CW'(1);
      POP_TWO: pop_len = CW'(2);
      default: pop_len = '0;
    endcase
  end

  // Storage has no reset; occupancy is tracked solely by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[tail] <= push_byte;
      addr_q[tail] <= push_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      head  <= head + PW'(pop_len);
      count <= count + CW'(push) - pop_len;
    end
  end

  assign next_idx  = head + PW'(1);
  assign head_byte = data_q[head];
  assign head_pc   = addr_q[head];
  assign next_byte = data_q[next_idx];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: streams ROM bytes into a prefetch FIFO, assembles one- or
// two-byte instructions for decode, and restarts fetch on redirect.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int              DEPTH    = DEPTH_DEFAULT,
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT),
  parameter logic [1:0]      IMM_OP   = IMM_OP_CODE
) (
  input logic                    Clk,
  input logic                    Reset,
  fetch_prefetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] req_addr;
  logic            inflight;
  logic            reset_q;
  logic [CW-1:0]   count;
  logic [CW:0]     occupancy;
  logic [7:0]      head_byte;
  logic [7:0]      next_byte;
  logic [PC_W-1:0] head_pc;
  logic            mem_req;
  logic            push;
  logic            head_imm;
  logic            avail;
  logic            out_valid;
  logic [7:0]      out_code;
  logic [7:0]      out_imm;
  logic [PC_W-1:0] out_pc;
  logic            out_imm_sel;
  pop_e            pop;

  // Occupancy counts the outstanding response, so a granted request always has a slot.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight);
  assign mem_req   = !reset_q && !bus.Redirect_Valid && (occupancy < (CW+1)'(DEPTH));
  assign push      = inflight && !bus.Redirect_Valid && !Reset;

  assign bus.Mem_Req  = mem_req;
  assign bus.Mem_Addr = pc;

  always_ff @(posedge Clk) begin
    reset_q <= Reset;
  end

  // Clearing inflight on reset/redirect is what kills a stale ROM response.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
    end else if (bus.Redirect_Valid) begin
      pc       <= bus.Redirect_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_req;
      if (mem_req) pc <= pc + PC_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_req) req_addr <= pc;
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_fifo (
    .clk       (Clk),
    .rst       (Reset),
    .flush     (bus.Redirect_Valid),
    .push      (push),
    .push_byte (bus.Mem_RData),
    .push_pc   (req_addr),
    .pop       (pop),
    .head_byte (head_byte),
    .head_pc   (head_pc),
    .next_byte (next_byte),
    .count     (count)
  );

  always_comb begin
    head_imm    = is_imm_class(head_byte, IMM_OP);
    avail       = head_imm ? (count >= CW'(2)) : (count >= CW'(1));
    out_valid   = avail && !bus.Redirect_Valid;
    out_code    = '0;
    out_imm     = '0;
    out_pc      = '0;
    out_imm_sel = 1'b0;
    pop         = POP_NONE;
    if (out_valid) begin
      out_code    = head_byte;
      out_pc      = head_pc;
      out_imm_sel = head_imm;
      out_imm     = head_imm ? next_byte : 8'h00;
      if (bus.Out_Ready) pop = head_imm ? POP_TWO : POP_ONE;
    end
  end

  assign bus.Out_Valid  = out_valid;
  assign bus.Out_Code   = out_code;
  assign bus.Out_Imm    = out_imm;
  assign bus.Out_PC     = out_pc;
  assign bus.Out_ImmSel = out_imm_sel;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: synchronous ROM model plus an instruction
// stream reference that parses the ROM image from each fetch start address.
module tb_fetch_prefetch_queue;

  logic Clk = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] rom [256];

  always #5 Clk = ~Clk;

  fetch_prefetch_queue_if #(.PC_W(8)) bus();

  fetch_prefetch_queue #(
    .DEPTH    (4),
    .PC_W     (8),
    .RESET_PC (8'h00),
    .IMM_OP   (2'b00)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // ROM: data valid the cycle after a request, garbage otherwise.
  always @(posedge Clk) begin
    if (bus.Mem_Req === 1'b1) bus.Mem_RData <= rom[bus.Mem_Addr];
    else                      bus.Mem_RData <= 8'($urandom);
  end

  // Instruction found at address p when decoding the ROM image directly.
  function automatic void model(input logic [7:0] p, output logic [7:0] code,
                                output logic [7:0] imm, output logic sel,
                                output logic [7:0] np);
    logic [7:0] p1;
    p1   = p + 8'd1;
    code = rom[p];
    if (code[7:6] == 2'b00) begin
      imm = rom[p1];
      sel = 1'b1;
      np  = p + 8'd2;
    end else begin
      imm = 8'h00;
      sel = 1'b0;
      np  = p1;
    end
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    bus.Redirect_Valid = 1'b0;
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic get_txn(output logic [7:0] code, output logic [7:0] imm,
                         output logic [7:0] pc, output logic sel, output int cyc);
    cyc = 0;
    code = '0; imm = '0; pc = '0; sel = 1'b0;
    forever begin
      #1;
      if (bus.Out_Valid && bus.Out_Ready) begin
        code = bus.Out_Code; imm = bus.Out_Imm; pc = bus.Out_PC; sel = bus.Out_ImmSel;
        step();
        cyc++;
        return;
      end
      step();
      cyc++;
      if (cyc >= 50) begin
        n_checks++; n_fail++;
        $display("FAIL txn_timeout: no instruction accepted in %0d cycles, required one", cyc);
        return;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] code, imm, pc;
    logic sel;
    int cyc;
    logic [7:0] e_code [3] = '{8'h48, 8'h0F, 8'h88};
    logic [7:0] e_imm  [3] = '{8'h00, 8'h50, 8'h00};
    logic [7:0] e_pc   [3] = '{8'h00, 8'h01, 8'h03};
    logic       e_sel  [3] = '{1'b0, 1'b1, 1'b0};
    for (int a = 0; a < 256; a++) rom[a] = 8'h80;
    rom[0] = 8'h48; rom[1] = 8'h0F; rom[2] = 8'h50; rom[3] = 8'h88;
    bus.Out_Ready = 1'b1;
    do_reset();
    #1;
    n_checks++;
    if ({bus.Mem_Req, bus.Out_Valid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_req_valid: got %b required 00", {bus.Mem_Req, bus.Out_Valid});
    end
    n_checks++;
    if (bus.Mem_Addr !== 8'h00) begin
      n_fail++; $display("FAIL reset_addr: got %h required 00", bus.Mem_Addr);
    end
    n_checks++;
    if ({bus.Out_Code, bus.Out_Imm, bus.Out_PC, bus.Out_ImmSel} !== 25'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0",
                         {bus.Out_Code, bus.Out_Imm, bus.Out_PC, bus.Out_ImmSel});
    end
    step();
    n_checks++;
    if ({bus.Mem_Req, bus.Mem_Addr} !== 9'h100) begin
      n_fail++; $display("FAIL first_req: got req=%b addr=%h required req=1 addr=00",
                         bus.Mem_Req, bus.Mem_Addr);
    end
    for (int i = 0; i < 3; i++) begin
      get_txn(code, imm, pc, sel, cyc);
      n_checks++;
      if ({code, imm, pc, sel} !== {e_code[i], e_imm[i], e_pc[i], e_sel[i]}) begin
        n_fail++; $display("FAIL reset_stream[%0d]: got code=%h imm=%h pc=%h sel=%b required %h %h %h %b",
                           i, code, imm, pc, sel, e_code[i], e_imm[i], e_pc[i], e_sel[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] code, imm, pc, ec, ei, np, p;
    logic sel, es;
    int cyc, reqs, bytes, cycles;
    for (int a = 0; a < 256; a++) rom[a] = 8'((a * 37 + 91) & 255);
    bus.Out_Ready = 1'b0;
    do_reset();
    model(8'h00, ec, ei, es, np);
    reqs = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (bus.Mem_Req) reqs++;
      if (bus.Out_Valid) begin
        n_checks++;
        if ({bus.Out_Code, bus.Out_PC} !== {ec, 8'h00}) begin
          n_fail++; $display("FAIL hold_stable[%0d]: got code=%h pc=%h required %h 00",
                             i, bus.Out_Code, bus.Out_PC, ec);
        end
      end
      step();
    end
    #1;
    n_checks++;
    if (reqs !== 4) begin
      n_fail++; $display("FAIL hold_fill: got %0d requests required 4", reqs);
    end
    n_checks++;
    if ({bus.Mem_Req, bus.Out_Valid} !== 2'b01) begin
      n_fail++; $display("FAIL hold_full: got req=%b valid=%b required req=0 valid=1",
                         bus.Mem_Req, bus.Out_Valid);
    end
    bus.Out_Ready = 1'b1;
    p = 8'h00; bytes = 0; cycles = 0;
    for (int i = 0; i < 14; i++) begin
      get_txn(code, imm, pc, sel, cyc);
      cycles += cyc;
      model(p, ec, ei, es, np);
      n_checks++;
      if ({code, imm, pc, sel} !== {ec, ei, p, es}) begin
        n_fail++; $display("FAIL hold_release[%0d]: got code=%h imm=%h pc=%h sel=%b required %h %h %h %b",
                           i, code, imm, pc, sel, ec, ei, p, es);
      end
      bytes += es ? 2 : 1;
      p = np;
    end
    n_checks++;
    if (cycles > bytes + 3) begin
      n_fail++; $display("FAIL throughput: got %0d cycles for %0d bytes required at most %0d",
                         cycles, bytes, bytes + 3);
    end
  endtask

  task automatic test_redirect_kill();
    logic [7:0] code, imm, pc, ec, ei, np, p;
    logic sel, es, found;
    int cyc;
    for (int a = 0; a < 256; a++) rom[a] = 8'h40 | 8'(a & 63);
    rom[8'h05] = 8'hE5;
    rom[8'h20] = 8'h9C; rom[8'h21] = 8'h03; rom[8'h22] = 8'h5A;
    bus.Out_Ready = 1'b1;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (bus.Mem_Req && bus.Mem_Addr == 8'h05) found = 1'b1;
      step();
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL kill_setup: got no request to 05 required one within 20 cycles");
    end
    bus.Redirect_Valid = 1'b1;
    bus.Redirect_PC    = 8'h20;
    #1;
    n_checks++;
    if (bus.Out_Valid !== 1'b0) begin
      n_fail++; $display("FAIL redirect_gate: got valid=%b required 0", bus.Out_Valid);
    end
    step();
    bus.Redirect_Valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.Out_Valid, bus.Mem_Req, bus.Mem_Addr} !== {1'b0, 1'b1, 8'h20}) begin
      n_fail++; $display("FAIL redirect_issue: got valid=%b req=%b addr=%h required 0 1 20",
                         bus.Out_Valid, bus.Mem_Req, bus.Mem_Addr);
    end
    step();
    n_checks++;
    if (bus.Out_Valid !== 1'b0) begin
      n_fail++; $display("FAIL redirect_early: got valid=%b required 0", bus.Out_Valid);
    end
    step();
    n_checks++;
    if ({bus.Out_Valid, bus.Out_PC, bus.Out_Code} !== {1'b1, 8'h20, 8'h9C}) begin
      n_fail++; $display("FAIL redirect_latency: got valid=%b pc=%h code=%h required 1 20 9c",
                         bus.Out_Valid, bus.Out_PC, bus.Out_Code);
    end
    p = 8'h20;
    for (int i = 0; i < 4; i++) begin
      get_txn(code, imm, pc, sel, cyc);
      model(p, ec, ei, es, np);
      n_checks++;
      if ({code, imm, pc, sel} !== {ec, ei, p, es}) begin
        n_fail++; $display("FAIL redirect_stream[%0d]: got code=%h imm=%h pc=%h sel=%b required %h %h %h %b",
                           i, code, imm, pc, sel, ec, ei, p, es);
      end
      p = np;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] code, imm, pc;
    logic sel;
    int cyc;
    for (int a = 0; a < 256; a++) rom[a] = 8'h80;
    rom[8'hFF] = 8'h01; rom[8'h00] = 8'hAA; rom[8'h01] = 8'h77;
    bus.Out_Ready = 1'b1;
    do_reset();
    step();
    step();
    bus.Redirect_Valid = 1'b1;
    bus.Redirect_PC    = 8'hFF;
    step();
    bus.Redirect_Valid = 1'b0;
    get_txn(code, imm, pc, sel, cyc);
    n_checks++;
    if ({code, imm, pc, sel} !== {8'h01, 8'hAA, 8'hFF, 1'b1}) begin
      n_fail++; $display("FAIL wrap_imm: got code=%h imm=%h pc=%h sel=%b required 01 aa ff 1",
                         code, imm, pc, sel);
    end
    get_txn(code, imm, pc, sel, cyc);
    n_checks++;
    if ({code, imm, pc, sel} !== {8'h77, 8'h00, 8'h01, 1'b0}) begin
      n_fail++; $display("FAIL wrap_next: got code=%h imm=%h pc=%h sel=%b required 77 00 01 0",
                         code, imm, pc, sel);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] code, imm, pc, ec, ei, np, p;
    logic sel, es;
    int cyc;
    for (int a = 0; a < 256; a++) rom[a] = 8'h40 | 8'(a & 63);
    bus.Out_Ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.Out_Valid, bus.Mem_Req, bus.Mem_Addr} !== {1'b0, 1'b0, 8'h00}) begin
      n_fail++; $display("FAIL mid_reset: got valid=%b req=%b addr=%h required 0 0 00",
                         bus.Out_Valid, bus.Mem_Req, bus.Mem_Addr);
    end
    bus.Out_Ready = 1'b1;
    p = 8'h00;
    for (int i = 0; i < 4; i++) begin
      get_txn(code, imm, pc, sel, cyc);
      model(p, ec, ei, es, np);
      n_checks++;
      if ({code, imm, pc, sel} !== {ec, ei, p, es}) begin
        n_fail++; $display("FAIL mid_reset_stream[%0d]: got code=%h imm=%h pc=%h sel=%b required %h %h %h %b",
                           i, code, imm, pc, sel, ec, ei, p, es);
      end
      p = np;
    end
  endtask

  task automatic test_random();
    logic [7:0] ec, ei, np, exp_pc;
    logic es, redir;
    int ntx;
    for (int a = 0; a < 256; a++) rom[a] = 8'(a);
    bus.Out_Ready = 1'b0;
    do_reset();
    exp_pc = 8'h00;
    ntx = 0;
    for (int i = 0; i < 800; i++) begin
      bus.Out_Ready = ($urandom_range(0, 9) < 7);
      redir = ($urandom_range(0, 31) == 0);
      bus.Redirect_Valid = redir;
      if (redir) bus.Redirect_PC = 8'($urandom);
      #1;
      if (redir) begin
        n_checks++;
        if (bus.Out_Valid !== 1'b0) begin
          n_fail++; $display("FAIL rand_gate[%0d]: got valid=%b required 0", i, bus.Out_Valid);
        end
        exp_pc = bus.Redirect_PC;
      end else if (bus.Out_Valid && bus.Out_Ready) begin
        model(exp_pc, ec, ei, es, np);
        n_checks++;
        if ({bus.Out_Code, bus.Out_Imm, bus.Out_PC, bus.Out_ImmSel} !== {ec, ei, exp_pc, es}) begin
          n_fail++; $display("FAIL rand_txn[%0d]: got code=%h imm=%h pc=%h sel=%b required %h %h %h %b",
                             i, bus.Out_Code, bus.Out_Imm, bus.Out_PC, bus.Out_ImmSel, ec, ei, exp_pc, es);
        end
        exp_pc = np;
        ntx++;
      end
      step();
    end
    bus.Redirect_Valid = 1'b0;
    n_checks++;
    if (ntx <= 150) begin
      n_fail++; $display("FAIL rand_progress: got %0d instructions required more than 150", ntx);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    Reset              = 1'b1;
    bus.Redirect_Valid = 1'b0;
    bus.Redirect_PC    = 8'h00;
    bus.Out_Ready      = 1'b0;
    test_reset();
    test_hold();
    test_redirect_kill();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
